// File: rtl/cipher_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cipher_ctrl_pkg
// Description : Shared types and constants for the cipher session controller:
//               session FSM state encoding, byte width and default key/IV
//               values used by benches.
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WARM  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [BYTE_W-1:0] DEFAULT_KEY1 = 8'hAA;
    localparam logic [BYTE_W-1:0] DEFAULT_KEY2 = 8'hCC;
    localparam logic [BYTE_W-1:0] DEFAULT_KEY3 = 8'hF0;
    localparam logic [BYTE_W-1:0] DEFAULT_IV1  = 8'h0F;
    localparam logic [BYTE_W-1:0] DEFAULT_IV2  = 8'h33;
    localparam logic [BYTE_W-1:0] DEFAULT_IV3  = 8'h55;

endpackage
`default_nettype wire

// File: rtl/cipher_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : cipher_out_stage
// Description : One-entry valid/ready output register. Accepts a data byte
//               when enabled and empty (or draining this cycle) and stores it
//               XORed with the current keystream byte.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               enable              - FSM allows new input (RUN state)
//               in_valid/in_data    - upstream byte
//               ks_byte             - keystream byte paired with the input
//               in_ready, fire      - acceptance and accept-this-cycle
//               out_valid/out_ready/out_data - downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_out_stage
    import cipher_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    input  logic [BYTE_W-1:0] ks_byte,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              fire,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data
);

    logic              r_valid;
    logic [BYTE_W-1:0] r_data;

    // The register can take a new byte in the same cycle the held one leaves.
    always_comb begin
        in_ready = enable && (!r_valid || out_ready);
        fire     = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (fire) begin
            r_valid <= 1'b1;
            r_data  <= in_data ^ ks_byte;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/cipher_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cipher_session_ctrl
// Description : Session controller for the three-LFSR keyed-IV stream cipher
//               core. Latches key/IV/length on start, pulses core_load,
//               discards WARMUP keystream bytes, then streams length bytes
//               through a valid/ready path XORed with the keystream.
// Ports       : clk, rst                 - clock, sync active-high reset
//               start, key1..3, iv1..3, length - session request
//               busy, done               - session status
//               core_load, core_key*, core_iv*, core_step, ks_byte - core IF
//               in_valid/in_ready/in_data    - input byte stream
//               out_valid/out_ready/out_data - output byte stream
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_session_ctrl
    import cipher_ctrl_pkg::*;
#(
    parameter int unsigned WARMUP = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] key1,
    input  logic [BYTE_W-1:0] key2,
    input  logic [BYTE_W-1:0] key3,
    input  logic [BYTE_W-1:0] iv1,
    input  logic [BYTE_W-1:0] iv2,
    input  logic [BYTE_W-1:0] iv3,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              core_load,
    output logic [BYTE_W-1:0] core_key1,
    output logic [BYTE_W-1:0] core_key2,
    output logic [BYTE_W-1:0] core_key3,
    output logic [BYTE_W-1:0] core_iv1,
    output logic [BYTE_W-1:0] core_iv2,
    output logic [BYTE_W-1:0] core_iv3,
    output logic              core_step,
    input  logic [BYTE_W-1:0] ks_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data
);

    localparam logic [7:0] c_warmup = 8'(WARMUP);

    state_t            r_state;
    state_t            w_next;
    logic              r_done;
    logic [7:0]        r_warm_cnt;
    logic [LEN_W-1:0]  r_remain;
    logic [BYTE_W-1:0] r_key1, r_key2, r_key3, r_iv1, r_iv2, r_iv3;
    logic              w_run;
    logic              w_fire;
    logic              w_step;

    cipher_out_stage u_out_stage (
        .clk       (clk),
        .rst       (rst),
        .enable    (w_run),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .ks_byte   (ks_byte),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .fire      (w_fire),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always_comb begin
        w_next = r_state;
        w_run  = 1'b0;
        w_step = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (length != '0)) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_next = (WARMUP == 0) ? S_RUN : S_WARM;
            end
            S_WARM: begin
                w_step = 1'b1;
                if (r_warm_cnt == 8'd1) w_next = S_RUN;
            end
            S_RUN: begin
                w_run  = 1'b1;
                // Each accepted byte consumes exactly one keystream step.
                w_step = w_fire;
                if (w_fire && (r_remain == LEN_W'(1))) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_valid && out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_warm_cnt <= '0;
            r_remain   <= '0;
            r_key1     <= '0;
            r_key2     <= '0;
            r_key3     <= '0;
            r_iv1      <= '0;
            r_iv2      <= '0;
            r_iv3      <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            // Empty session completes without touching the core.
                            r_done <= 1'b1;
                        end else begin
                            r_key1   <= key1;
                            r_key2   <= key2;
                            r_key3   <= key3;
                            r_iv1    <= iv1;
                            r_iv2    <= iv2;
                            r_iv3    <= iv3;
                            r_remain <= length;
                        end
                    end
                end
                S_LOAD:  r_warm_cnt <= c_warmup;
                S_WARM:  r_warm_cnt <= r_warm_cnt - 8'd1;
                S_RUN: begin
                    if (w_fire) r_remain <= r_remain - LEN_W'(1);
                end
                S_DRAIN: begin
                    if (out_valid && out_ready) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign core_load = (r_state == S_LOAD);
    assign core_step = w_step;
    assign core_key1 = r_key1;
    assign core_key2 = r_key2;
    assign core_key3 = r_key3;
    assign core_iv1  = r_iv1;
    assign core_iv2  = r_iv2;
    assign core_iv3  = r_iv3;

endmodule
`default_nettype wire
